// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with one shared prescaled period counter.
// Period/duty writes are shadowed and applied only at a period wrap.
module pwm_multi_channel #(
    parameter int CH    = 5,
    parameter int CNT_W = 8,
    parameter int PRE_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_enable,
    input  logic [PRE_W-1:0]    i_prescale,
    input  logic [CNT_W-1:0]    i_period,
    input  logic [CH*CNT_W-1:0] i_duty,
    input  logic [CH-1:0]       i_polarity,
    input  logic                i_load,
    output logic [CH-1:0]       o_pwm,
    output logic                o_period_end,
    output logic                o_load_ack
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    per_a_q, per_a_d;
    logic [CNT_W-1:0]    per_s_q, per_s_d;
    logic [CH*CNT_W-1:0] duty_a_q, duty_a_d;
    logic [CH*CNT_W-1:0] duty_s_q, duty_s_d;
    logic                pend_q, pend_d;
    logic [CH-1:0]       pwm_q, pwm_d;
    logic                pe_q, pe_d;
    logic                ack_q, ack_d;

    logic                tick;
    logic                wrap;
    logic [CH-1:0]       act;

    assign tick = (pre_q == i_prescale);

    // Raw per-channel activity before polarity; duty > period saturates to 100%.
    always_comb begin
        act = '0;
        for (int k = 0; k < CH; k++) begin
            act[k] = (cnt_q < duty_a_q[k*CNT_W +: CNT_W]);
        end
    end

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        per_a_d  = per_a_q;
        per_s_d  = per_s_q;
        duty_a_d = duty_a_q;
        duty_s_d = duty_s_q;
        pend_d   = pend_q;
        pwm_d    = pwm_q;
        pe_d     = 1'b0;
        ack_d    = 1'b0;
        wrap     = 1'b0;

        unique case (state_q)
            IDLE: begin
                pre_d = '0;
                cnt_d = '0;
                pwm_d = i_polarity;
                if (i_load) begin
                    per_a_d  = i_period;
                    duty_a_d = i_duty;
                    pend_d   = 1'b0;
                    ack_d    = 1'b1;
                end
                if (i_enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!i_enable) begin
                    state_d = IDLE;
                    pre_d   = '0;
                    cnt_d   = '0;
                    pwm_d   = i_polarity;
                    if (i_load) begin
                        per_s_d  = i_period;
                        duty_s_d = i_duty;
                        pend_d   = 1'b1;
                    end
                end else begin
                    pwm_d = act ^ i_polarity;
                    if (tick) begin
                        pre_d = '0;
                        if (cnt_q >= per_a_q) begin
                            wrap  = 1'b1;
                            cnt_d = '0;
                            pe_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end

                    // A load landing on the wrap cycle bypasses the shadow.
                    if (i_load && wrap) begin
                        per_a_d  = i_period;
                        duty_a_d = i_duty;
                        per_s_d  = i_period;
                        duty_s_d = i_duty;
                        pend_d   = 1'b0;
                        ack_d    = 1'b1;
                    end else if (wrap && pend_q) begin
                        per_a_d  = per_s_q;
                        duty_a_d = duty_s_q;
                        pend_d   = 1'b0;
                        ack_d    = 1'b1;
                    end else if (i_load) begin
                        per_s_d  = i_period;
                        duty_s_d = i_duty;
                        pend_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            cnt_q    <= '0;
            per_a_q  <= '0;
            per_s_q  <= '0;
            duty_a_q <= '0;
            duty_s_q <= '0;
            pend_q   <= 1'b0;
            pwm_q    <= '0;
            pe_q     <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            per_a_q  <= per_a_d;
            per_s_q  <= per_s_d;
            duty_a_q <= duty_a_d;
            duty_s_q <= duty_s_d;
            pend_q   <= pend_d;
            pwm_q    <= pwm_d;
            pe_q     <= pe_d;
            ack_q    <= ack_d;
        end
    end

    assign o_pwm        = pwm_q;
    assign o_period_end = pe_q;
    assign o_load_ack   = ack_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel: a period/offset reference model
// queues the expected outputs per clock; a monitor pops and compares them.
module tb_pwm_multi_channel;
    localparam int CH    = 5;
    localparam int CNT_W = 8;
    localparam int PRE_W = 8;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                i_enable = 1'b0;
    logic [PRE_W-1:0]    i_prescale = '0;
    logic [CNT_W-1:0]    i_period = '0;
    logic [CH*CNT_W-1:0] i_duty = '0;
    logic [CH-1:0]       i_polarity = '0;
    logic                i_load = 1'b0;
    logic [CH-1:0]       o_pwm;
    logic                o_period_end;
    logic                o_load_ack;

    pwm_multi_channel #(.CH(CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_enable     (i_enable),
        .i_prescale   (i_prescale),
        .i_period     (i_period),
        .i_duty       (i_duty),
        .i_polarity   (i_polarity),
        .i_load       (i_load),
        .o_pwm        (o_pwm),
        .o_period_end (o_period_end),
        .o_load_ack   (o_load_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [CH+1:0] expq[$];

    // Stimulus settings applied on the next step
    int         t_pre = 0;
    int         t_per = 0;
    int         t_duty[CH];
    bit [CH-1:0] t_pol = '0;

    // Reference model: run flag, cycle offset inside the current period,
    // active and pending parameter sets.
    bit m_run;
    int m_o;
    int m_per;
    int m_duty[CH];
    bit m_pend;
    int m_sper;
    int m_sduty[CH];

    function automatic void model_reset();
        m_run = 0; m_o = 0; m_per = 0; m_pend = 0; m_sper = 0;
        for (int k = 0; k < CH; k++) begin
            m_duty[k] = 0;
            m_sduty[k] = 0;
        end
    endfunction

    task automatic step(input bit en, input bit ld);
        bit [CH-1:0] epwm;
        bit epe, eack;
        int len;
        @(negedge clk);
        i_enable   = en;
        i_load     = ld;
        i_prescale = PRE_W'(t_pre);
        i_period   = CNT_W'(t_per);
        i_polarity = t_pol;
        for (int k = 0; k < CH; k++) i_duty[k*CNT_W +: CNT_W] = CNT_W'(t_duty[k]);
        epwm = t_pol; epe = 0; eack = 0;
        if (!m_run) begin
            eack = ld;
            if (ld) begin
                m_per = t_per; m_pend = 0;
                for (int k = 0; k < CH; k++) m_duty[k] = t_duty[k];
            end
            if (en) begin m_run = 1; m_o = 0; end
        end else if (!en) begin
            if (ld) begin
                m_sper = t_per; m_pend = 1;
                for (int k = 0; k < CH; k++) m_sduty[k] = t_duty[k];
            end
            m_run = 0;
        end else begin
            len = (t_pre + 1) * (m_per + 1);
            for (int k = 0; k < CH; k++)
                epwm[k] = ((m_o / (t_pre + 1)) < m_duty[k]) ^ t_pol[k];
            epe = (m_o == len - 1);
            if (ld) begin
                m_sper = t_per; m_pend = 1;
                for (int k = 0; k < CH; k++) m_sduty[k] = t_duty[k];
            end
            eack = epe && m_pend;
            if (epe) begin
                if (m_pend) begin
                    m_per = m_sper;
                    for (int k = 0; k < CH; k++) m_duty[k] = m_sduty[k];
                end
                m_pend = 0;
                m_o = 0;
            end else begin
                m_o++;
            end
        end
        expq.push_back({epwm, epe, eack});
    endtask

    task automatic run(input int n, input bit en);
        repeat (n) step(en, 1'b0);
    endtask

    task automatic set_duty_all(input int d);
        for (int k = 0; k < CH; k++) t_duty[k] = d;
    endtask

    always @(posedge clk) begin
        logic [CH+1:0] e, a;
        #1;
        if (reset_n && expq.size() > 0) begin
            e = expq.pop_front();
            a = {o_pwm, o_period_end, o_load_ack};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL out t=%0t: got pwm=%b pe=%b ack=%b want pwm=%b pe=%b ack=%b",
                         $time, a[CH+1:2], a[1], a[0], e[CH+1:2], e[1], e[0]);
            end
        end
    end

    task automatic check_reset_outputs(input string nm);
        n_cmp++;
        if ({o_pwm, o_period_end, o_load_ack} !== '0) begin
            n_bad++;
            $display("FAIL %s: got pwm=%b pe=%b ack=%b want all 0",
                     nm, o_pwm, o_period_end, o_load_ack);
        end
    endtask

    int guard;

    initial begin
        model_reset();
        set_duty_all(0);
        #1;
        check_reset_outputs("reset_init");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Released idle with polarity 0 keeps outputs low
        t_pol = '0;
        run(4, 0);

        // Polarity shows through in idle and at 0% duty while running
        t_pol = 5'b10101; t_pre = 0; t_per = 3; set_duty_all(0);
        run(2, 0);
        step(0, 1);
        run(13, 1);

        // Per-channel duties 0..4 over a 4-clk period
        run(1, 0);
        t_pol = '0;
        for (int k = 0; k < CH; k++) t_duty[k] = k;
        step(0, 1);
        run(17, 1);

        // Prescale 2: 6 high / 6 low, 12-clk period
        run(1, 0);
        t_pre = 2; set_duty_all(2);
        step(0, 1);
        run(37, 1);

        // Shadow load mid-period takes effect at the next wrap
        run(1, 0);
        t_pre = 0; t_per = 3; set_duty_all(1);
        step(0, 1);
        run(2, 1);
        set_duty_all(3);
        step(1, 1);
        run(12, 1);

        // Disable at cnt = 2, then re-enable
        guard = 0;
        while (m_o != 2 && guard < 100) begin
            step(1, 0);
            guard++;
        end
        n_cmp++;
        if (m_o != 2) begin
            n_bad++;
            $display("FAIL reach_cnt2: got offset=%0d want 2", m_o);
        end
        run(3, 0);
        run(12, 1);

        // Asynchronous reset mid-run with inverted polarity
        t_pol = 5'b10101; set_duty_all(2);
        run(1, 0);
        step(0, 1);
        run(7, 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        i_enable = 1'b0;
        i_load = 1'b0;
        #1;
        check_reset_outputs("reset_midrun");
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        t_pol = '0;
        run(4, 0);

        // Randomized segments
        for (int s = 0; s < 16; s++) begin
            t_pre = $urandom_range(0, 3);
            t_per = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 20) : $urandom_range(0, 7);
            for (int k = 0; k < CH; k++) t_duty[k] = $urandom_range(0, t_per + 2);
            t_pol = CH'($urandom);
            run(1, 0);
            if (!m_pend) step(0, 1);
            else run(1, 0);
            step(1, 0);
            for (int c = 0, n = $urandom_range(20, 90); c < n; c++) begin
                if ($urandom_range(0, 14) == 0) begin
                    t_per = $urandom_range(0, 9);
                    for (int k = 0; k < CH; k++) t_duty[k] = $urandom_range(0, t_per + 2);
                    step(1, 1);
                end else begin
                    step(1, 0);
                end
            end
        end
        run(3, 0);

        guard = 0;
        while (expq.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (expq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
